// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared glyph table (active-high, a..g with a in index 0) and sizing helper
// for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

   localparam logic [0:6] SEG_0   = 7'b1111110;
   localparam logic [0:6] SEG_1   = 7'b0110000;
   localparam logic [0:6] SEG_2   = 7'b1101101;
   localparam logic [0:6] SEG_3   = 7'b1111001;
   localparam logic [0:6] SEG_4   = 7'b0110011;
   localparam logic [0:6] SEG_5   = 7'b1011011;
   localparam logic [0:6] SEG_6   = 7'b1011111;
   localparam logic [0:6] SEG_7   = 7'b1110000;
   localparam logic [0:6] SEG_8   = 7'b1111111;
   localparam logic [0:6] SEG_9   = 7'b1111011;
   localparam logic [0:6] SEG_A   = 7'b1110111;
   localparam logic [0:6] SEG_B   = 7'b0011111;
   localparam logic [0:6] SEG_C   = 7'b1001110;
   localparam logic [0:6] SEG_D   = 7'b0111101;
   localparam logic [0:6] SEG_E   = 7'b1001111;
   localparam logic [0:6] SEG_F   = 7'b1000111;
   localparam logic [0:6] SEG_OFF = 7'b0000000;

   // Never returns less than 1 so degenerate counters still get a real bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int p = 1; p < value; p = p * 2) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/seg7_scan_ctrl_decode.sv
// Combinational digit-code to active-high segment decoder; polarity is applied
// only at the scan controller's output registers.
module seg7_decode
   import seg7_scan_ctrl_pkg::*;
(
   input  logic [3:0] code,
   input  logic       hex_en,
   input  logic       blank,
   output logic [0:6] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (!blank) begin
         case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = hex_en ? SEG_A : SEG_OFF;
            4'hB: seg = hex_en ? SEG_B : SEG_OFF;
            4'hC: seg = hex_en ? SEG_C : SEG_OFF;
            4'hD: seg = hex_en ? SEG_D : SEG_OFF;
            4'hE: seg = hex_en ? SEG_E : SEG_OFF;
            default: seg = hex_en ? SEG_F : SEG_OFF;
         endcase
      end
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scanner with double-buffered digits,
// leading-zero blanking, per-digit blink and inter-digit anode blanking.
module seg7_scan_ctrl
   import seg7_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 1000,
   parameter int BLANK_CYC      = 2,
   parameter int BLINK_FRAMES   = 64,
   parameter bit HEX_MODE       = 1'b0,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic                    lz_blank,
   input  logic                    load,
   output logic [0:6]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = clog2(DIV);
   localparam int IW  = clog2(NUM_DIGITS);
   localparam int FW  = clog2(BLINK_FRAMES);

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend, act;
   logic [NUM_DIGITS-1:0]   dp_pend, dp_act;
   logic                    blink_on;
   logic [FW-1:0]           frame_cnt;

   logic                    tick, boundary;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic [3:0]              cur_code;
   logic                    cur_blank;
   logic [0:6]              glyph;
   logic [NUM_DIGITS-1:0]   an_raw;

   assign tick     = (cnt == CW'(DIV - 1));
   assign boundary = tick && (idx == IW'(NUM_DIGITS - 1));

   // A digit is a leading zero when it and everything above it are zero.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      lz_mask    = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         upper_zero = upper_zero && (act[4*k +: 4] == 4'h0);
         lz_mask[k] = lz_blank && upper_zero && (k != 0);
      end
   end

   assign cur_code  = act[{idx, 2'b00} +: 4];
   assign cur_blank = lz_mask[idx] | (blink_en[idx] & ~blink_on);
   assign an_raw    = (cnt >= CW'(BLANK_CYC)) ? (NUM_DIGITS'(1) << idx) : '0;

   seg7_decode u_decode (
      .code   (cur_code),
      .hex_en (HEX_MODE),
      .blank  (cur_blank),
      .seg    (glyph)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         pend       <= '0;
         act        <= '0;
         dp_pend    <= '0;
         dp_act     <= '0;
         blink_on   <= 1'b1;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
         seg        <= {7{SEG_ACTIVE_LOW}};
         dp         <= SEG_ACTIVE_LOW;
         an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
      end else begin
         cnt <= tick ? '0 : cnt + 1'b1;
         if (tick) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         if (load) begin
            pend    <= digits_in;
            dp_pend <= dp_in;
         end
         // A load landing on the boundary bypasses pend so it is not lost a frame.
         if (boundary) begin
            act    <= load ? digits_in : pend;
            dp_act <= load ? dp_in : dp_pend;
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
               frame_cnt <= '0;
               blink_on  <= ~blink_on;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end
         frame_done <= boundary;
         seg        <= SEG_ACTIVE_LOW ? ~glyph : glyph;
         dp         <= SEG_ACTIVE_LOW ? ~(dp_act[idx] & ~cur_blank) : (dp_act[idx] & ~cur_blank);
         an         <= AN_ACTIVE_LOW ? ~an_raw : an_raw;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: DIV=4, BLANK_CYC=1, 4 digits, one
// instance per HEX_MODE setting sharing the same stimulus.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0, blink_en = '0;
   logic        lz_blank = 1'b0, load = 1'b0;
   logic [0:6]  seg0, seg1;
   logic        dp0, dp1, fd0, fd1;
   logic [3:0]  an0, an1;

   int total = 0;
   int bad   = 0;
   int k     = 0;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(16), .SCAN_HZ(4), .BLANK_CYC(1),
      .BLINK_FRAMES(2), .HEX_MODE(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut0 (
      .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blink_en(blink_en),
      .lz_blank(lz_blank), .load(load), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));

   seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_HZ(16), .SCAN_HZ(4), .BLANK_CYC(1),
      .BLINK_FRAMES(2), .HEX_MODE(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut1 (
      .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blink_en(blink_en),
      .lz_blank(lz_blank), .load(load), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Output after edge k reflects the scan state reached after edge k-1.
   function automatic int dig_of(input int kk);
      return ((kk - 1) / 4) % 4;
   endfunction

   function automatic logic [3:0] exp_an(input int kk);
      logic [3:0] one;
      one = 4'b0001;
      return (((kk - 1) % 4) < 1) ? 4'hF : ~(one << dig_of(kk));
   endfunction

   function automatic bit is_blank(input logic [15:0] v, input int d, input bit lz, input bit dark);
      return dark || (lz && d > 0 && (v >> (4 * d)) == 16'h0);
   endfunction

   function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit lz,
                                          input bit dark, input bit hex);
      logic [3:0] c;
      c = v[4*d +: 4];
      if (is_blank(v, d, lz, dark)) return 7'h7F;
      if (c > 4'd9 && !hex) return 7'h7F;
      return ~GLYPH[c];
   endfunction

   task automatic test_reset();
      repeat (3) step();
      total++; if (an0 !== 4'hF) begin bad++; $display("FAIL reset_an got=%b exp=1111", an0); end
      total++; if (seg0 !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%b exp=1111111", seg0); end
      rst = 1'b0;
      repeat (6) step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (an0 !== 4'hF) begin bad++; $display("FAIL midreset_an got=%b exp=1111", an0); end
         total++; if (seg0 !== 7'h7F) begin bad++; $display("FAIL midreset_seg got=%b exp=1111111", seg0); end
         total++; if (dp0 !== 1'b1) begin bad++; $display("FAIL midreset_dp got=%b exp=1", dp0); end
         total++; if (fd0 !== 1'b0) begin bad++; $display("FAIL midreset_fd got=%b exp=0", fd0); end
      end
      rst = 1'b0;
      k = 0;
      step();
      total++; if (an0 !== 4'hF) begin bad++; $display("FAIL release_blank_an got=%b exp=1111", an0); end
      total++; if (seg0 !== 7'b0000001) begin bad++; $display("FAIL release_seg got=%b exp=0000001", seg0); end
      step();
      total++; if (an0 !== 4'b1110) begin bad++; $display("FAIL release_first_an got=%b exp=1110", an0); end
   endtask

   task automatic test_scan_order();
      logic [6:0] es;
      digits_in = 16'h4321; load = 1'b1;
      step();
      load = 1'b0;
      while (k < 16) step();
      for (int i = 0; i < 16; i++) begin
         step();
         es = exp_seg(16'h4321, dig_of(k), 1'b0, 1'b0, 1'b0);
         total++; if (an0 !== exp_an(k)) begin bad++; $display("FAIL scan_an k=%0d got=%b exp=%b", k, an0, exp_an(k)); end
         total++; if (seg0 !== es) begin bad++; $display("FAIL scan_seg k=%0d got=%b exp=%b", k, seg0, es); end
         total++; if (fd0 !== (k % 16 == 0)) begin bad++; $display("FAIL scan_fd k=%0d got=%b", k, fd0); end
      end
   endtask

   task automatic test_tearing();
      logic [15:0] v;
      logic [6:0]  es;
      for (int i = 0; i < 48; i++) begin
         if (k == 37) begin digits_in = 16'h9999; load = 1'b1; end
         if (k == 63) begin digits_in = 16'h5678; load = 1'b1; end
         step();
         load = 1'b0;
         v  = (k <= 48) ? 16'h4321 : (k <= 64) ? 16'h9999 : 16'h5678;
         es = exp_seg(v, dig_of(k), 1'b0, 1'b0, 1'b0);
         total++; if (an0 !== exp_an(k)) begin bad++; $display("FAIL tear_an k=%0d got=%b exp=%b", k, an0, exp_an(k)); end
         total++; if (seg0 !== es) begin bad++; $display("FAIL tear_seg k=%0d got=%b exp=%b", k, seg0, es); end
      end
   endtask

   task automatic test_lz();
      logic [15:0] v;
      logic [3:0]  dv;
      logic [6:0]  es;
      logic        ed;
      lz_blank = 1'b1;
      for (int i = 0; i < 48; i++) begin
         if (k == 80) begin digits_in = 16'h0070; dp_in = 4'b1010; load = 1'b1; end
         if (k == 99) begin digits_in = 16'h0000; dp_in = 4'b0000; load = 1'b1; end
         step();
         load = 1'b0;
         v  = (k <= 96) ? 16'h5678 : (k <= 112) ? 16'h0070 : 16'h0000;
         dv = (k <= 96) ? 4'b0000 : (k <= 112) ? 4'b1010 : 4'b0000;
         es = exp_seg(v, dig_of(k), 1'b1, 1'b0, 1'b0);
         ed = is_blank(v, dig_of(k), 1'b1, 1'b0) ? 1'b1 : ~dv[dig_of(k)];
         total++; if (an0 !== exp_an(k)) begin bad++; $display("FAIL lz_an k=%0d got=%b exp=%b", k, an0, exp_an(k)); end
         total++; if (seg0 !== es) begin bad++; $display("FAIL lz_seg k=%0d got=%b exp=%b", k, seg0, es); end
         total++; if (dp0 !== ed) begin bad++; $display("FAIL lz_dp k=%0d got=%b exp=%b", k, dp0, ed); end
      end
      lz_blank = 1'b0;
   endtask

   task automatic test_hex();
      logic [15:0] v;
      logic [6:0]  e0, e1;
      for (int i = 0; i < 32; i++) begin
         if (k == 128) begin digits_in = 16'h000B; load = 1'b1; end
         step();
         load = 1'b0;
         v  = (k <= 144) ? 16'h0000 : 16'h000B;
         e0 = exp_seg(v, dig_of(k), 1'b0, 1'b0, 1'b0);
         e1 = exp_seg(v, dig_of(k), 1'b0, 1'b0, 1'b1);
         total++; if (seg0 !== e0) begin bad++; $display("FAIL hex0_seg k=%0d got=%b exp=%b", k, seg0, e0); end
         total++; if (seg1 !== e1) begin bad++; $display("FAIL hex1_seg k=%0d got=%b exp=%b", k, seg1, e1); end
      end
   endtask

   task automatic test_blink();
      logic [15:0] v;
      logic [6:0]  es;
      bit          dark;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++; if (an0 !== 4'hF) begin bad++; $display("FAIL blink_reset_an got=%b exp=1111", an0); end
      k = 0;
      digits_in = 16'h4321; dp_in = 4'b0001; blink_en = 4'b0001;
      for (int i = 0; i < 96; i++) begin
         load = (i == 0);
         step();
         load = 1'b0;
         v    = (k <= 16) ? 16'h0000 : 16'h4321;
         dark = blink_en[dig_of(k)] && ((((k - 1) / 16) / 2) % 2 == 1);
         es   = exp_seg(v, dig_of(k), 1'b0, dark, 1'b0);
         total++; if (an0 !== exp_an(k)) begin bad++; $display("FAIL blink_an k=%0d got=%b exp=%b", k, an0, exp_an(k)); end
         total++; if (seg0 !== es) begin bad++; $display("FAIL blink_seg k=%0d got=%b exp=%b", k, seg0, es); end
         if (k > 16) begin
            total++;
            if (dp0 !== ((dig_of(k) == 0 && !dark) ? 1'b0 : 1'b1)) begin
               bad++; $display("FAIL blink_dp k=%0d got=%b dark=%0d", k, dp0, dark);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_tearing();
      test_lz();
      test_hex();
      test_blink();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
